// File: rtl/hsi_vector_obi_initiator.sv
// rtl/hsi_vector_obi_initiator.sv - OBI initiator that runs one HSI vector job through the core register wrapper
//
// Purpose: accepts one job (op, pixel_size), writes PIXEL_SIZE then CTRL(start), polls STATUS until
// valid_result, reads RESULT and hands it out on a valid/ready result port. Bus errors (timeout, poll
// limit) and illegal ops finish the job with res_err_o=1 and res_data_o=0.
// Ports:
//   clk_i, rst_i                     clock, asynchronous active-high reset
//   job_valid_i/job_ready_o          job handshake; job_op_i[1:0], job_size_i[15:0] latched on accept
//   req_o, addr_o, we_o, wdata_o     OBI request (req_o is a one-cycle pulse per transaction)
//   rvalid_i, rdata_i                OBI response (returned for reads and writes)
//   res_valid_o/res_ready_i          result handshake; res_data_o[15:0], res_err_o
//   busy_o                           job in progress
module hsi_vector_obi_initiator #(
  parameter int TIMEOUT   = 16,
  parameter int POLL_GAP  = 4,
  parameter int MAX_POLLS = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        job_valid_i,
  output logic        job_ready_o,
  input  logic [1:0]  job_op_i,
  input  logic [15:0] job_size_i,
  output logic        req_o,
  output logic [7:0]  addr_o,
  output logic        we_o,
  output logic [31:0] wdata_o,
  input  logic [31:0] rdata_i,
  input  logic        rvalid_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [15:0] res_data_o,
  output logic        res_err_o,
  output logic        busy_o
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int PW = $clog2(MAX_POLLS + 1);
  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [TW-1:0] TIMEOUT_L = TW'(TIMEOUT);
  localparam logic [PW-1:0] POLLS_L   = PW'(MAX_POLLS);
  localparam logic [GW-1:0] GAP_LAST  = GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_SIZE   = 8'h04;
  localparam logic [7:0] ADDR_STATUS = 8'h08;
  localparam logic [7:0] ADDR_RESULT = 8'h0C;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_SIZE, S_WR_CTRL, S_RD_STAT, S_GAP, S_RD_RES, S_RESP
  } state_t;

  state_t        r_state;
  logic          r_req;
  logic [7:0]    r_addr;
  logic          r_we;
  logic [31:0]   r_wdata;
  logic          r_res_valid;
  logic [15:0]   r_res_data;
  logic          r_res_err;
  logic          r_job_ready;
  logic          r_busy;
  logic [TW-1:0] r_timer;
  logic [PW-1:0] r_polls;
  logic [GW-1:0] r_gap;
  logic [1:0]    r_op;

  // Only STATUS bit 1 and RESULT[15:0] carry information for this initiator.
  logic w_unused_rdata;
  assign w_unused_rdata = ^rdata_i[31:16];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_req       <= 1'b0;
      r_addr      <= 8'h00;
      r_we        <= 1'b0;
      r_wdata     <= 32'h0;
      r_res_valid <= 1'b0;
      r_res_data  <= 16'h0;
      r_res_err   <= 1'b0;
      r_job_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_timer     <= '0;
      r_polls     <= '0;
      r_gap       <= '0;
      r_op        <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (job_valid_i) begin
            r_op        <= job_op_i;
            r_polls     <= '0;
            r_job_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (job_op_i == 2'd3) begin
              // Illegal op is answered straight away without touching the bus.
              r_state     <= S_RESP;
              r_res_valid <= 1'b1;
              r_res_err   <= 1'b1;
              r_res_data  <= 16'h0;
            end else begin
              r_state <= S_WR_SIZE;
              r_req   <= 1'b1;
              r_addr  <= ADDR_SIZE;
              r_we    <= 1'b1;
              r_wdata <= {16'h0, job_size_i};
            end
          end
        end

        S_GAP: begin
          if (r_gap == GAP_LAST) begin
            r_state <= S_RD_STAT;
            r_req   <= 1'b1;
            r_addr  <= ADDR_STATUS;
            r_we    <= 1'b0;
            r_polls <= r_polls + PW'(1);
          end else begin
            r_gap <= r_gap + GW'(1);
          end
        end

        S_RESP: begin
          if (res_ready_i) begin
            r_res_valid <= 1'b0;
            r_state     <= S_IDLE;
            r_job_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end

        default: begin
          // Bus states: the cycle with req_o high is the issue phase and ignores rvalid_i;
          // afterwards the timer counts wait cycles, so rvalid_i up to TIMEOUT cycles after
          // the request is still taken and the abort shows one cycle later.
          if (r_req) begin
            r_req   <= 1'b0;
            r_timer <= TW'(1);
          end else if (rvalid_i) begin
            case (r_state)
              S_WR_SIZE: begin
                r_state <= S_WR_CTRL;
                r_req   <= 1'b1;
                r_addr  <= ADDR_CTRL;
                r_we    <= 1'b1;
                r_wdata <= {29'd0, r_op, 1'b1};
              end
              S_WR_CTRL: begin
                r_state <= S_RD_STAT;
                r_req   <= 1'b1;
                r_addr  <= ADDR_STATUS;
                r_we    <= 1'b0;
                r_polls <= r_polls + PW'(1);
              end
              S_RD_STAT: begin
                if (rdata_i[1]) begin
                  r_state <= S_RD_RES;
                  r_req   <= 1'b1;
                  r_addr  <= ADDR_RESULT;
                  r_we    <= 1'b0;
                end else if (r_polls == POLLS_L) begin
                  r_state     <= S_RESP;
                  r_res_valid <= 1'b1;
                  r_res_err   <= 1'b1;
                  r_res_data  <= 16'h0;
                end else if (POLL_GAP == 0) begin
                  r_req   <= 1'b1;
                  r_addr  <= ADDR_STATUS;
                  r_we    <= 1'b0;
                  r_polls <= r_polls + PW'(1);
                end else begin
                  r_state <= S_GAP;
                  r_gap   <= '0;
                end
              end
              S_RD_RES: begin
                r_state     <= S_RESP;
                r_res_valid <= 1'b1;
                r_res_err   <= 1'b0;
                r_res_data  <= rdata_i[15:0];
              end
              default: ;
            endcase
          end else if (r_timer == TIMEOUT_L) begin
            r_state     <= S_RESP;
            r_res_valid <= 1'b1;
            r_res_err   <= 1'b1;
            r_res_data  <= 16'h0;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
      endcase
    end
  end

  assign job_ready_o = r_job_ready;
  assign req_o       = r_req;
  assign addr_o      = r_addr;
  assign we_o        = r_we;
  assign wdata_o     = r_wdata;
  assign res_valid_o = r_res_valid;
  assign res_data_o  = r_res_data;
  assign res_err_o   = r_res_err;
  assign busy_o      = r_busy;

endmodule

// File: tb/tb_hsi_vector_obi_initiator.sv
// tb/tb_hsi_vector_obi_initiator.sv - scoreboard bench for hsi_vector_obi_initiator
module tb_hsi_vector_obi_initiator;

  localparam int TIMEOUT   = 16;
  localparam int POLL_GAP  = 4;
  localparam int MAX_POLLS = 256;
  localparam int NEVER     = 1 << 30;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        job_valid_i = 1'b0;
  logic        job_ready_o;
  logic [1:0]  job_op_i = 2'd0;
  logic [15:0] job_size_i = 16'h0;
  logic        req_o;
  logic [7:0]  addr_o;
  logic        we_o;
  logic [31:0] wdata_o;
  logic [31:0] rdata_i = 32'h0;
  logic        rvalid_i = 1'b0;
  logic        res_valid_o;
  logic        res_ready_i = 1'b0;
  logic [15:0] res_data_o;
  logic        res_err_o;
  logic        busy_o;

  always #5 clk_i = ~clk_i;

  hsi_vector_obi_initiator #(
    .TIMEOUT(TIMEOUT), .POLL_GAP(POLL_GAP), .MAX_POLLS(MAX_POLLS)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
    .job_op_i(job_op_i), .job_size_i(job_size_i),
    .req_o(req_o), .addr_o(addr_o), .we_o(we_o), .wdata_o(wdata_o),
    .rdata_i(rdata_i), .rvalid_i(rvalid_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_data_o(res_data_o), .res_err_o(res_err_o), .busy_o(busy_o)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed { logic [7:0] addr; logic we; logic [31:0] wdata; } bus_t;
  typedef struct packed { logic [15:0] data; logic err; } res_t;
  bus_t exp_bus[$];
  res_t exp_res[$];

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Responder state
  int          stat_ready_after = 0;
  logic [15:0] result_val = 16'h0;
  bit          withhold_ctrl = 1'b0;
  int          late_at = -1;
  int          ctrl_req_cyc = 0;
  int          stat_reads = 0;
  int          res_reads = 0;
  int          n_reqs = 0;
  int          req_cycs[$];
  int          stat_cycs[$];
  bit          pend = 1'b0;
  logic [31:0] pend_data = 32'h0;

  always @(negedge clk_i) begin : responder
    bus_t e;
    if (rst_i) begin
      rvalid_i = 1'b0;
      pend = 1'b0;
    end else begin
      rvalid_i = pend;
      rdata_i  = pend ? pend_data : 32'hDEAD_0000;
      if (late_at == cyc) begin
        rvalid_i = 1'b1;
        rdata_i  = 32'h0000_0002;
        late_at  = -1;
      end
      pend = 1'b0;
      if (req_o) begin
        n_reqs++;
        req_cycs.push_back(cyc);
        check("bus_pending", exp_bus.size() != 0, 1);
        if (exp_bus.size() != 0) begin
          e = exp_bus.pop_front();
          check("bus_addr", addr_o, e.addr);
          check("bus_we", we_o, e.we);
          if (e.we) check("bus_wdata", wdata_o, e.wdata);
        end
        case (addr_o)
          8'h08: begin
            pend_data = (stat_reads >= stat_ready_after) ? 32'h2 : 32'h1;
            stat_reads++;
            stat_cycs.push_back(cyc);
          end
          8'h0C: begin
            pend_data = {16'h0, result_val};
            res_reads++;
          end
          default: pend_data = 32'h0;
        endcase
        if (withhold_ctrl && addr_o == 8'h00 && we_o) begin
          ctrl_req_cyc = cyc;
          late_at = cyc + TIMEOUT + 4;
        end else begin
          pend = 1'b1;
        end
      end
    end
  end

  int res_hs_cyc = 0;
  int n_res = 0;

  always @(negedge clk_i) begin : res_monitor
    res_t r;
    if (!rst_i && res_valid_o && res_ready_i) begin
      check("res_pending", exp_res.size() != 0, 1);
      if (exp_res.size() != 0) begin
        r = exp_res.pop_front();
        check("res_data", res_data_o, r.data);
        check("res_err", res_err_o, r.err);
      end
      res_hs_cyc = cyc;
      n_res++;
    end
  end

  task automatic push_job(input logic [1:0] op, input logic [15:0] size, input int n_stat,
                          input bit ok, input logic [15:0] data);
    bus_t b;
    res_t r;
    if (op != 2'd3) begin
      b.addr = 8'h04; b.we = 1'b1; b.wdata = {16'h0, size};        exp_bus.push_back(b);
      b.addr = 8'h00; b.we = 1'b1; b.wdata = {29'd0, op, 1'b1};     exp_bus.push_back(b);
      for (int i = 0; i < n_stat; i++) begin
        b.addr = 8'h08; b.we = 1'b0; b.wdata = 32'h0; exp_bus.push_back(b);
      end
      if (ok) begin
        b.addr = 8'h0C; b.we = 1'b0; b.wdata = 32'h0; exp_bus.push_back(b);
      end
    end
    r.data = ok ? data : 16'h0;
    r.err  = !ok;
    exp_res.push_back(r);
  endtask

  // Called at posedge+#1; returns at posedge+#1 of the cycle after acceptance.
  task automatic start_job(input logic [1:0] op, input logic [15:0] size, output int t_acc);
    job_valid_i = 1'b1;
    job_op_i    = op;
    job_size_i  = size;
    t_acc = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk_i);
      if (job_ready_o) begin
        t_acc = cyc;
        break;
      end
    end
    check("job_accepted", t_acc >= 0, 1);
    @(posedge clk_i);
    #1;
    job_valid_i = 1'b0;
  endtask

  task automatic wait_res(input int n_before, input int budget);
    for (int k = 0; k < budget && n_res == n_before; k++) @(posedge clk_i);
    check("res_seen", n_res != n_before, 1);
    #1;
  endtask

  task automatic check_reset_outs(input string tag);
    check(tag, {job_ready_o, req_o, we_o, res_valid_o, res_err_o, busy_o, addr_o, wdata_o, res_data_o},
          {6'b100000, 56'd0});
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t, t2, n0, nq, gmin, gmax, d;

    repeat (3) @(posedge clk_i);
    #1;
    check_reset_outs("reset_outputs");
    rst_i = 1'b0;
    res_ready_i = 1'b1;
    @(posedge clk_i);
    #1;

    // 1: nominal job, ready on first poll
    result_val = 16'hBEEF; stat_ready_after = 0; req_cycs.delete();
    push_job(2'd2, 16'd64, 1, 1'b1, 16'hBEEF);
    n0 = n_res;
    start_job(2'd2, 16'd64, t);
    wait_res(n0, 100);
    check("t1_req_count", req_cycs.size(), 4);
    check("t1_first_req", req_cycs[0] - t, 1);
    check("t1_last_req", req_cycs[3] - t, 7);
    check("t1_res_latency", res_hs_cyc - t, 9);

    // 2: three busy polls, then ready
    result_val = 16'h1234; stat_ready_after = 3; stat_reads = 0; stat_cycs.delete();
    push_job(2'd1, 16'h0100, 4, 1'b1, 16'h1234);
    n0 = n_res;
    start_job(2'd1, 16'h0100, t);
    wait_res(n0, 200);
    check("t2_stat_reads", stat_reads, 4);
    gmin = NEVER; gmax = 0;
    for (int i = 1; i < stat_cycs.size(); i++) begin
      d = stat_cycs[i] - stat_cycs[i-1];
      if (d < gmin) gmin = d;
      if (d > gmax) gmax = d;
    end
    check("t2_min_read_spacing", gmin, POLL_GAP + 2);
    check("t2_max_read_spacing", gmax, POLL_GAP + 2);

    // 3: STATUS never ready -> poll limit error
    stat_ready_after = NEVER; stat_reads = 0; res_reads = 0;
    push_job(2'd0, 16'h0010, MAX_POLLS, 1'b0, 16'h0);
    n0 = n_res;
    start_job(2'd0, 16'h0010, t);
    wait_res(n0, 3000);
    check("t3_stat_reads", stat_reads, MAX_POLLS);
    check("t3_result_reads", res_reads, 0);
    check("t3_bus_queue_empty", exp_bus.size(), 0);

    // 4: CTRL write never answered -> timeout, late rvalid ignored
    withhold_ctrl = 1'b1; stat_ready_after = 0;
    push_job(2'd2, 16'd5, 0, 1'b0, 16'h0);
    n0 = n_res;
    start_job(2'd2, 16'd5, t);
    wait_res(n0, 100);
    withhold_ctrl = 1'b0;
    check("t4_timeout_latency", res_hs_cyc - ctrl_req_cyc, TIMEOUT + 1);
    nq = n_reqs;
    repeat (8) @(posedge clk_i);
    #1;
    check("t4_late_ignored", {n_reqs == nq, busy_o, job_ready_o, res_valid_o}, 4'b1010);

    // 5: illegal op, result held back, then back-to-back job
    res_ready_i = 1'b0;
    push_job(2'd3, 16'h0001, 0, 1'b0, 16'h0);
    nq = n_reqs;
    start_job(2'd3, 16'h0001, t);
    job_valid_i = 1'b1; job_op_i = 2'd1; job_size_i = 16'd7;
    @(negedge clk_i);
    check("t5_res_next_cycle", cyc - t, 1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk_i);
      check("t5_hold_outputs", {res_valid_o, res_err_o, res_data_o, busy_o, job_ready_o}, {2'b11, 16'h0, 2'b10});
    end
    check("t5_no_bus", n_reqs - nq, 0);
    @(posedge clk_i);
    #1;
    res_ready_i = 1'b1;
    result_val = 16'h0055; stat_ready_after = 0;
    push_job(2'd1, 16'd7, 1, 1'b1, 16'h0055);
    start_job(2'd1, 16'd7, t2);
    check("t5_accept_after_hs", t2 - res_hs_cyc, 1);
    n0 = n_res;
    wait_res(n0, 100);

    // 6: reset during STATUS wait, then a clean job
    stat_ready_after = NEVER; stat_reads = 0;
    push_job(2'd2, 16'd3, MAX_POLLS, 1'b0, 16'h0);
    start_job(2'd2, 16'd3, t);
    for (int k = 0; k < 40 && stat_reads == 0; k++) @(negedge clk_i);
    check("t6_reached_poll", stat_reads, 1);
    @(posedge clk_i);
    #2;
    check("t6_in_wait", {busy_o, req_o, addr_o}, {2'b10, 8'h08});
    rst_i = 1'b1;
    #1;
    check_reset_outs("t6_async_reset");
    exp_bus.delete();
    exp_res.delete();
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    result_val = 16'hCAFE; stat_ready_after = 0; req_cycs.delete();
    push_job(2'd0, 16'hFFFF, 1, 1'b1, 16'hCAFE);
    n0 = n_res;
    start_job(2'd0, 16'hFFFF, t);
    wait_res(n0, 100);
    check("t6_req_count", req_cycs.size(), 4);
    check("t6_res_latency", res_hs_cyc - t, 9);

    check("end_bus_queue", exp_bus.size(), 0);
    check("end_res_queue", exp_res.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
